// File: rtl/nco_lut_scheduler.sv
// NCO phase accumulator sequencing one shared sine LUT into sin/cos LO samples.
// Define NCO_QUADRATURE_EN for the cosine lookup; otherwise sine only, cos_out = 0.
module nco_lut_scheduler #(
    parameter int PHASE_WIDTH = 32,
    parameter int LUT_DEPTH   = 8,
    parameter int DATA_WIDTH  = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic [PHASE_WIDTH-1:0]       freq_word,
    input  logic                         freq_load,
    input  logic                         phase_clear,
    output logic [LUT_DEPTH-1:0]         lut_address,
    input  logic signed [DATA_WIDTH-1:0] lut_value,
    output logic signed [DATA_WIDTH-1:0] sin_out,
    output logic signed [DATA_WIDTH-1:0] cos_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

`ifdef NCO_QUADRATURE_EN
    typedef enum logic [1:0] {IDLE, SIN, COS} state_t;
    localparam logic [LUT_DEPTH-1:0] QTR = LUT_DEPTH'(1) << (LUT_DEPTH - 2);
`else
    typedef enum logic {IDLE, SIN} state_t;
`endif

    state_t                         state_q, state_d;
    logic [PHASE_WIDTH-1:0]         acc_q, acc_d;
    logic [PHASE_WIDTH-1:0]         inc_q, inc_d;
    logic [PHASE_WIDTH-1:0]         inc_eff;
    // only the LUT address bits of the sampled phase are ever consumed
    logic [LUT_DEPTH-1:0]           base_q, base_d;
    logic signed [DATA_WIDTH-1:0]   sin_q, sin_d;
    logic                           out_valid_q, out_valid_d;
    logic                           overrun_q, overrun_d;
`ifdef NCO_QUADRATURE_EN
    logic signed [DATA_WIDTH-1:0]   sin_hold_q, sin_hold_d;
    logic signed [DATA_WIDTH-1:0]   cos_q, cos_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            inc_q       <= '0;
            base_q      <= '0;
            sin_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef NCO_QUADRATURE_EN
            sin_hold_q  <= '0;
            cos_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            base_q      <= base_d;
            sin_q       <= sin_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef NCO_QUADRATURE_EN
            sin_hold_q  <= sin_hold_d;
            cos_q       <= cos_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        inc_d       = inc_q;
        base_d      = base_q;
        sin_d       = sin_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        inc_eff     = freq_load ? freq_word : inc_q;
`ifdef NCO_QUADRATURE_EN
        sin_hold_d  = sin_hold_q;
        cos_d       = cos_q;
`endif
        if (freq_load)
            inc_d = freq_word;
        if (phase_clear)
            acc_d = '0;
        if (sample_tick && state_q != IDLE)
            overrun_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = SIN;
                    if (phase_clear) begin
                        base_d = '0;
                        acc_d  = inc_eff;
                    end else begin
                        base_d = acc_q[PHASE_WIDTH-1 -: LUT_DEPTH];
                        acc_d  = acc_q + inc_eff;
                    end
                end
            end
`ifdef NCO_QUADRATURE_EN
            SIN: begin
                sin_hold_d = lut_value;
                state_d    = COS;
            end
            COS: begin
                sin_d       = sin_hold_q;
                cos_d       = lut_value;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
`else
            SIN: begin
                sin_d       = lut_value;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
`endif
        endcase
    end

    always_comb begin
        lut_address = base_q;
`ifdef NCO_QUADRATURE_EN
        if (state_q == COS)
            lut_address = base_q + QTR;
`endif
    end

    assign busy      = (state_q != IDLE);
    assign sin_out   = sin_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
`ifdef NCO_QUADRATURE_EN
    assign cos_out   = cos_q;
`else
    assign cos_out   = '0;
`endif

endmodule

// File: tb/tb_nco_lut_scheduler.sv
// Directed bench for nco_lut_scheduler with a small sine LUT model.
// Adapts latency and cosine expectations to NCO_QUADRATURE_EN.
module tb_nco_lut_scheduler;

`ifdef NCO_QUADRATURE_EN
    localparam int LAT  = 3;
    localparam bit QUAD = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit QUAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [31:0] freq_word;
    logic        freq_load;
    logic        phase_clear;
    logic [7:0]  lut_address;
    logic [6:0]  lut_value;
    logic [6:0]  sin_out;
    logic [6:0]  cos_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int errs   = 0;
    int checks = 0;

    nco_lut_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .freq_word   (freq_word),
        .freq_load   (freq_load),
        .phase_clear (phase_clear),
        .lut_address (lut_address),
        .lut_value   (lut_value),
        .sin_out     (sin_out),
        .cos_out     (cos_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // 63*sin(2*pi*a/256) truncated, for the addresses this bench visits
    function automatic logic [6:0] lut_f(input logic [7:0] a);
        case (a)
            8'd0:    return 7'h00;
            8'd1:    return 7'h01;
            8'd2:    return 7'h03;
            8'd64:   return 7'h3F;
            8'd65:   return 7'h3E;
            8'd66:   return 7'h3E;
            8'd128:  return 7'h00;
            8'd192:  return 7'h41;
            default: return 7'h2A;
        endcase
    endfunction

    assign lut_value = lut_f(lut_address);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_and_check(input string tag, input logic [7:0] base,
                                  input logic [6:0] es, input logic [6:0] ec);
        logic [6:0] ec_eff;
        ec_eff = QUAD ? ec : 7'h00;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        freq_load   = 1'b0;
        phase_clear = 1'b0;
        chk({tag, "_sadr"}, lut_address, base);
        chk({tag, "_busy1"}, busy, 1);
        chk({tag, "_nv1"}, out_valid, 0);
`ifdef NCO_QUADRATURE_EN
        step();
        chk({tag, "_cadr"}, lut_address, 8'(base + 8'd64));
        chk({tag, "_busy2"}, busy, 1);
        chk({tag, "_nv2"}, out_valid, 0);
`endif
        step();
        chk({tag, "_v"}, out_valid, 1);
        chk({tag, "_sin"}, sin_out, es);
        chk({tag, "_cos"}, cos_out, ec_eff);
        chk({tag, "_idle"}, busy, 0);
        step();
        chk({tag, "_vlo"}, out_valid, 0);
        chk({tag, "_hold"}, sin_out, es);
    endtask

    task automatic load_clear(input logic [31:0] fw);
        freq_word   = fw;
        freq_load   = 1'b1;
        phase_clear = 1'b1;
        step();
        freq_load   = 1'b0;
        phase_clear = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        sample_tick = 1'b0;
        freq_word   = '0;
        freq_load   = 1'b0;
        phase_clear = 1'b0;
        step();
        step();
        chk("rst_sin", sin_out, 0);
        chk("rst_cos", cos_out, 0);
        chk("rst_v", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_adr", lut_address, 0);
        reset = 1'b0;
        step();

        load_clear(32'h0100_0000);
        tick_and_check("f1a", 8'd0, 7'h00, 7'h3F);
        tick_and_check("f1b", 8'd1, 7'h01, 7'h3E);
        tick_and_check("f1c", 8'd2, 7'h03, 7'h3E);

        load_clear(32'h4000_0000);
        tick_and_check("q0", 8'd0,   7'h00, 7'h3F);
        tick_and_check("q1", 8'd64,  7'h3F, 7'h00);
        tick_and_check("q2", 8'd128, 7'h00, 7'h41);
        tick_and_check("q3", 8'd192, 7'h41, 7'h00);

        load_clear(32'hC000_0000);
        tick_and_check("w0", 8'd0,   7'h00, 7'h3F);
        tick_and_check("w1", 8'd192, 7'h41, 7'h00);
        tick_and_check("w2", 8'd128, 7'h00, 7'h41);
        tick_and_check("w3", 8'd64,  7'h3F, 7'h00);
        chk("wrap_ovr", overrun, 0);

        sample_tick = 1'b1;
        step();
        chk("ovr_c1", overrun, 0);
        step();
        sample_tick = 1'b0;
        for (int c = 2; c <= 2 * LAT + 1; c++) begin
            chk("ovr_v", out_valid, 32'((c == LAT) || (c == 2 * LAT)));
            chk("ovr_st", overrun, 1);
            sample_tick = (c == LAT);
            step();
        end
        sample_tick = 1'b0;

        phase_clear = 1'b1;
        step();
        phase_clear = 1'b0;
        freq_word   = 32'h0200_0000;
        freq_load   = 1'b1;
        tick_and_check("ld0", 8'd0, 7'h00, 7'h3F);
        tick_and_check("ld1", 8'd2, 7'h03, 7'h3E);
        phase_clear = 1'b1;
        tick_and_check("clr0", 8'd0, 7'h00, 7'h3F);
        tick_and_check("clr1", 8'd2, 7'h03, 7'h3E);

        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
`ifdef NCO_QUADRATURE_EN
        step();
`endif
        reset = 1'b1;
        #1;
        chk("arst_sin", sin_out, 0);
        chk("arst_cos", cos_out, 0);
        chk("arst_v", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_adr", lut_address, 0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_v", out_valid, 0);
            step();
        end
        tick_and_check("rst_tick", 8'd0, 7'h00, 7'h3F);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
